// File: rtl/byte_mem_pkg.sv
// Shared constants for the byte-addressed memory controller: FSM encoding and
// default geometry.
package byte_mem_pkg;

  localparam int DW_DEF      = 16;
  localparam int AW_DEF      = 16;
  localparam int DEPTH_DEF   = 16384;
  localparam int LATENCY_DEF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_mem_ctrl_if.sv
// Request/response bus of the byte memory controller (four-phase REQ/ACK).
interface byte_mem_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
) ();
  localparam int NB = DW / 8;

  logic [AW-1:0] ADDR;
  logic [DW-1:0] DIN;
  logic [NB-1:0] BE;
  logic          REQ;
  logic          WEN;
  logic [DW-1:0] DOUT;
  logic          ACK;
  logic          ERR;

  modport master (output ADDR, DIN, BE, REQ, WEN, input DOUT, ACK, ERR);
  modport slave  (input ADDR, DIN, BE, REQ, WEN, output DOUT, ACK, ERR);
endinterface

// File: rtl/byte_mem_array.sv
// NB-lane byte RAM. Lane j carries bits [8j+7:8j], i.e. the byte at addr+(NB-1-j),
// giving big-endian placement; read is combinational, write per lane.
module byte_mem_array #(
  parameter int DW    = 16,
  parameter int DEPTH = 16384,
  parameter int IW    = 14
) (
  input  logic                CLK,
  input  logic [IW-1:0]       addr,
  input  logic [DW-1:0]       wdata,
  input  logic [DW/8-1:0]     we,
  output logic [DW-1:0]       rdata
);
  localparam int NB = DW / 8;
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  logic [7:0] mem [DEPTH];

  logic [NB-1:0][IW-1:0] lane_addr;
  logic [NB-1:0]         lane_ok;

  for (genvar j = 0; j < NB; j++) begin : g_lane
    assign lane_addr[j]    = addr + IW'(NB - 1 - j);
    // Non-power-of-two depths can index past the end; such lanes read as zero.
    assign lane_ok[j]      = {1'b0, lane_addr[j]} < DEPTH_W;
    assign rdata[8*j +: 8] = lane_ok[j] ? mem[lane_addr[j]] : 8'h00;
  end

  always_ff @(posedge CLK) begin
    for (int j = 0; j < NB; j++)
      if (we[j] && lane_ok[j]) mem[lane_addr[j]] <= wdata[8*j +: 8];
  end

endmodule

// File: rtl/byte_mem_ctrl.sv
// Byte-addressed memory controller: four-phase handshake, programmable wait
// states, byte enables, unaligned big-endian access and range checking.
module byte_mem_ctrl import byte_mem_pkg::*; #(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic            CLK,
  input  logic            nRST,
  byte_mem_ctrl_if.slave  bus
);
  localparam int NB = DW / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LAST_OFS = (AW+1)'(NB - 1);
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [3:0]  LAT_W    = 4'(LATENCY);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [NB-1:0] be;
    logic          wen;
  } req_t;

  state_t        state, state_nxt;
  req_t          in_req, req_q, acc;
  logic [3:0]    cnt;
  logic          fire, acc_err;
  logic [NB-1:0] lane_we;
  logic [DW-1:0] rdata, dout_q;
  logic          ack_q, err_q;

  assign in_req = '{addr: bus.ADDR, din: bus.DIN, be: bus.BE, wen: bus.WEN};

  // With zero latency the access uses the live inputs on the accepting edge;
  // otherwise the latched request is replayed when the counter expires.
  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    acc       = req_q;
    case (state)
      IDLE: if (bus.REQ) begin
        acc = in_req;
        if (LATENCY == 0) begin
          fire      = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: if (cnt == 4'd1) begin
        fire      = 1'b1;
        state_nxt = DONE;
      end
      DONE:    if (!bus.REQ) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Range check is done one bit wider than the address so it cannot wrap.
  assign acc_err = ({1'b0, acc.addr} + LAST_OFS) >= DEPTH_W;
  assign lane_we = (fire && nRST && acc.wen && !acc_err) ? acc.be : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req_q  <= '0;
      cnt    <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.REQ) begin
          req_q <= in_req;
          cnt   <= LAT_W;
        end
        WAIT: cnt <= cnt - 4'd1;
        DONE: if (!bus.REQ) begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
      if (fire) begin
        ack_q <= 1'b1;
        err_q <= acc_err;
        if (!acc.wen && !acc_err) dout_q <= rdata;
      end
    end
  end

  byte_mem_array #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) u_array (
    .CLK   (CLK),
    .addr  (acc.addr[IW-1:0]),
    .wdata (acc.din),
    .we    (lane_we),
    .rdata (rdata)
  );

  assign bus.DOUT = dout_q;
  assign bus.ACK  = ack_q;
  assign bus.ERR  = err_q;

endmodule
